// File: rtl/my_dff_pkg.sv
// Shared constants and parameter-legality check for the my_dff register/pipeline.
package my_dff_pkg;

  localparam int MY_DFF_WIDTH_DEF = 1;
  localparam int MY_DFF_DEPTH_DEF = 1;
  localparam int MY_DFF_DEPTH_MAX = 64;

  function automatic bit my_dff_params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 1) && (depth <= MY_DFF_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/my_dff_stage.sv
// One WIDTH-bit register stage with synchronous active-low reset to RESET_VAL.
module my_dff_stage
  import my_dff_pkg::*;
#(
  parameter int               WIDTH     = MY_DFF_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_d;
  logic [WIDTH-1:0] stage_q;

  always_comb begin
    stage_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stage_q <= RESET_VAL;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/my_dff.sv
// Parameterised D register / delay line of DEPTH stages with synchronous active-low reset.
// Optional per-bit edge detector on q is enabled by defining MY_DFF_EDGE_DET_EN.
module my_dff
  import my_dff_pkg::*;
#(
  parameter int               WIDTH     = MY_DFF_WIDTH_DEF,
  parameter int               DEPTH     = MY_DFF_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef MY_DFF_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
`endif
);

  if (!my_dff_params_ok(WIDTH, DEPTH)) begin : g_param_check
    $fatal(1, "my_dff: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
  end

  // chain[0] is the input; chain[i+1] is the output of stage i.
  logic [WIDTH-1:0] chain [DEPTH+1];

  assign chain[0] = d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    my_dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_i   (clk),
      .rst_n_i (rst),
      .d_i     (chain[i]),
      .q_o     (chain[i+1])
    );
  end

  assign q = chain[DEPTH];

`ifdef MY_DFF_EDGE_DET_EN
  // q_d holds last cycle's q; resetting it with the stages keeps both pulses low out of reset.
  logic [WIDTH-1:0] q_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_d <= RESET_VAL;
    end else begin
      q_d <= q;
    end
  end

  assign q_rise = q & ~q_d;
  assign q_fall = ~q & q_d;
`endif

endmodule

// File: tb/tb_my_dff.sv
// Self-checking bench for my_dff: default DFF instance plus an 8-bit, 3-deep pipeline instance.
module tb_my_dff;

  localparam int         DEP_B = 3;
  localparam logic [7:0] RV_B  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       d_a;
  logic       rst_b;
  logic [7:0] d_b;
  wire        q_a;
  wire  [7:0] q_b;
`ifdef MY_DFF_EDGE_DET_EN
  wire        rise_a, fall_a;
  wire  [7:0] rise_b, fall_b;
`endif

  always #20 clk = ~clk;

  my_dff dut_a (
    .clk (clk),
    .rst (rst_a),
    .d   (d_a),
    .q   (q_a)
`ifdef MY_DFF_EDGE_DET_EN
    ,
    .q_rise (rise_a),
    .q_fall (fall_a)
`endif
  );

  my_dff #(
    .WIDTH     (8),
    .DEPTH     (DEP_B),
    .RESET_VAL (RV_B)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .d   (d_b),
    .q   (q_b)
`ifdef MY_DFF_EDGE_DET_EN
    ,
    .q_rise (rise_b),
    .q_fall (fall_b)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: history of values accepted since the last reset.
  // Output is the value accepted DEPTH edges ago, or the reset value if none exists yet.
  bit         hist_a [$];
  bit   [7:0] hist_b [$];
  logic       mq_a, mqd_a;
  logic [7:0] mq_b, mqd_b;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (!rst_a) begin
      hist_a.delete();
      mq_a  = 1'b0;
      mqd_a = 1'b0;
    end else begin
      mqd_a = mq_a;
      hist_a.push_back(d_a);
      mq_a = hist_a[hist_a.size()-1];
      if (hist_a.size() > 1) void'(hist_a.pop_front());
    end
    if (!rst_b) begin
      hist_b.delete();
      mq_b  = RV_B;
      mqd_b = RV_B;
    end else begin
      mqd_b = mq_b;
      hist_b.push_back(d_b);
      mq_b = (hist_b.size() >= DEP_B) ? hist_b[hist_b.size()-DEP_B] : RV_B;
      if (hist_b.size() > DEP_B) void'(hist_b.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    chk("a_model", {7'b0, q_a}, {7'b0, mq_a});
    chk("b_model", q_b, mq_b);
`ifdef MY_DFF_EDGE_DET_EN
    chk("a_rise_model", {7'b0, rise_a}, {7'b0, mq_a & ~mqd_a});
    chk("a_fall_model", {7'b0, fall_a}, {7'b0, ~mq_a & mqd_a});
    chk("b_rise_model", rise_b, mq_b & ~mqd_b);
    chk("b_fall_model", fall_b, ~mq_b & mqd_b);
`endif
  endtask

  initial begin
    logic [7:0] pipe_in  [5];
    logic [7:0] pipe_exp [5];
    logic       seq_a    [4];
    logic       held_a;
    logic [7:0] held_b;

    // Held reset with toggling data
    rst_a = 1'b0;
    rst_b = 1'b0;
    d_a   = 1'b0;
    d_b   = 8'h00;
    for (int i = 0; i < 5; i++) begin
      d_a = i[0];
      d_b = 8'($urandom);
      tick();
      chk("held_rst_a", {7'b0, q_a}, 8'h00);
      chk("held_rst_b", q_b, RV_B);
    end

    // Single-edge release on the default DFF
    rst_a = 1'b1;
    d_a   = 1'b1;
    tick();
    chk("pulse_release", {7'b0, q_a}, 8'h01);
    rst_a = 1'b0;
    tick();
    chk("pulse_reassert", {7'b0, q_a}, 8'h00);

    // Run mode, DEPTH=1
    rst_a = 1'b1;
    seq_a = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      d_a = seq_a[i];
      tick();
      chk("run_a", {7'b0, q_a}, {7'b0, seq_a[i]});
    end

    // Pipeline, DEPTH=3, RESET_VAL=A5
    rst_b    = 1'b1;
    pipe_in  = '{8'h01, 8'h02, 8'h03, 8'h5A, 8'hC3};
    pipe_exp = '{RV_B, RV_B, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 5; i++) begin
      d_b = pipe_in[i];
      tick();
      chk("pipe_b", q_b, pipe_exp[i]);
    end
    rst_b = 1'b0;
    tick();
    chk("pipe_flush", q_b, RV_B);
    rst_b = 1'b1;
    tick();
    chk("pipe_after_flush", q_b, RV_B);

    // Reset glitch between edges has no effect
    held_a = q_a;
    held_b = q_b;
    #5;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #10;
    rst_a = 1'b1;
    rst_b = 1'b1;
    chk("glitch_a", {7'b0, q_a}, {7'b0, held_a});
    chk("glitch_b", q_b, held_b);
    tick();

`ifdef MY_DFF_EDGE_DET_EN
    // Edge pulses on the default DFF
    rst_a = 1'b0;
    d_a   = 1'b1;
    tick();
    chk("edge_rst_rise", {7'b0, rise_a}, 8'h00);
    chk("edge_rst_fall", {7'b0, fall_a}, 8'h00);
    rst_a = 1'b1;
    tick();
    chk("edge_rise_on", {7'b0, rise_a}, 8'h01);
    tick();
    chk("edge_rise_off", {7'b0, rise_a}, 8'h00);
    d_a = 1'b0;
    tick();
    chk("edge_fall_on", {7'b0, fall_a}, 8'h01);
    tick();
    chk("edge_fall_off", {7'b0, fall_a}, 8'h00);
`endif

    // Randomised traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      rst_a = ($urandom_range(0, 15) != 0);
      rst_b = ($urandom_range(0, 15) != 0);
      d_a   = 1'($urandom);
      d_b   = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
